dl_adder_arb: RTL and testbench

Round-robin arbiter that shares a single NUM_BITS adder (sum plus carry-out) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- One request is granted per cycle.
- The result is registered and returned on a single response channel tagged with the requester index.
- Sits between multiple issue sources (e.g. address-generation and counter-update paths) and one shared add resource.

---
 rtl/dl_adder_arb.sv | 130 +++++++++++++
 tb/tb_dl_adder_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_adder_arb.sv
// dl_adder_arb: round-robin arbiter sharing one NUM_BITS adder among NUM_REQ
// requesters. One request is granted per cycle. The sum and carry-out are
// registered and returned on a single response channel tagged with the
// requester index.
//
// Optional feature macro: DL_ADDER_ARB_OVF_STICKY_EN
//   When defined, adds ovf_clr (in) and ovf_sticky[NUM_REQ] (out). These are
//   per-requester sticky carry-out flags.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NUM_REQ]    per-requester request valid
//   req_ready[NUM_REQ]    per-requester accept (combinational, one-hot or zero)
//   req_a/req_b           packed operands, requester i at [i*NUM_BITS +: NUM_BITS]
//   rsp_valid/rsp_ready   response handshake
//   rsp_sum, rsp_cout     registered a+b and its unsigned carry-out
//   rsp_id                index of the requester that produced the response
module dl_adder_arb #(
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned NUM_REQ  = 4,
  localparam int unsigned ID_BITS = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_a,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NUM_BITS-1:0]         rsp_sum,
  output logic                        rsp_cout,
  output logic [ID_BITS-1:0]          rsp_id
`ifdef DL_ADDER_ARB_OVF_STICKY_EN
  ,
  input  logic                        ovf_clr,
  output logic [NUM_REQ-1:0]          ovf_sticky
`endif
);

  logic [ID_BITS-1:0]  ptr;
  logic [ID_BITS-1:0]  win;
  logic                found;
  logic                can_accept;
  logic                xfer;
  logic [NUM_BITS-1:0] a_sel;
  logic [NUM_BITS-1:0] b_sel;
  logic [NUM_BITS-1:0] sum_c;
  logic                cout_c;

  // Rotating priority search. The first pass covers indices >= ptr. The
  // second pass wraps around to the lowest set index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (ID_BITS'(i) >= ptr)) begin
        found = 1'b1;
        win   = ID_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = ID_BITS'(i);
      end
    end
  end

  // Accept only when the output slot is empty or being drained this cycle.
  // The rst_n term keeps req_ready low while reset is asserted.
  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer       = found && can_accept && rst_n;

  // One-hot grant, and operand mux for the winner.
  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_BITS'(i)) begin
        req_ready[i] = xfer;
        a_sel        = req_a[i*NUM_BITS +: NUM_BITS];
        b_sel        = req_b[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // Shared adder. The extra top bit is the unsigned carry-out.
  assign {cout_c, sum_c} = {1'b0, a_sel} + {1'b0, b_sel};

  // Round-robin pointer. It wraps at NUM_REQ, not at 2^ID_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (win == ID_BITS'(NUM_REQ - 1)) ? '0 : win + ID_BITS'(1);
    end
  end

  // One-entry response register. A load overwrites the slot; a pop without
  // a load clears valid and leaves the payload as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_c;
      rsp_cout  <= cout_c;
      rsp_id    <= win;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef DL_ADDER_ARB_OVF_STICKY_EN
  // Sticky carry flags. A set in the same cycle wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | (cout_c ? req_ready : '0);
    end
  end
`endif

endmodule

// File: tb/tb_dl_adder_arb.sv
// tb_dl_adder_arb: directed bench for dl_adder_arb. It uses a 4-requester
// instance and a 3-requester instance, both with NUM_BITS=8.
module tb_dl_adder_arb;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req_valid4;
  logic [3:0]  req_ready4;
  logic [31:0] a4;
  logic [31:0] b4;
  logic        rsp_valid4;
  logic        rsp_ready4;
  logic [7:0]  rsp_sum4;
  logic        rsp_cout4;
  logic [1:0]  rsp_id4;

  logic [2:0]  req_valid3;
  logic [2:0]  req_ready3;
  logic [23:0] a3;
  logic [23:0] b3;
  logic        rsp_valid3;
  logic        rsp_ready3;
  logic [7:0]  rsp_sum3;
  logic        rsp_cout3;
  logic [1:0]  rsp_id3;

`ifdef DL_ADDER_ARB_OVF_STICKY_EN
  logic        ovf_clr;
  logic [3:0]  ovf_sticky4;
  logic [2:0]  ovf_sticky3;
`endif

  int n_cmp;
  int n_bad;

  dl_adder_arb #(.NUM_BITS(8), .NUM_REQ(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid4),
    .req_ready (req_ready4),
    .req_a     (a4),
    .req_b     (b4),
    .rsp_valid (rsp_valid4),
    .rsp_ready (rsp_ready4),
    .rsp_sum   (rsp_sum4),
    .rsp_cout  (rsp_cout4),
    .rsp_id    (rsp_id4)
`ifdef DL_ADDER_ARB_OVF_STICKY_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky4)
`endif
  );

  dl_adder_arb #(.NUM_BITS(8), .NUM_REQ(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid3),
    .req_ready (req_ready3),
    .req_a     (a3),
    .req_b     (b3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_sum   (rsp_sum3),
    .rsp_cout  (rsp_cout3),
    .rsp_id    (rsp_id3)
`ifdef DL_ADDER_ARB_OVF_STICKY_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse that does not cross a clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_rsp4(input string tag, input logic v, input logic [7:0] s,
                            input logic c, input logic [1:0] id);
    check({tag, ".valid"}, 32'(rsp_valid4), 32'(v));
    check({tag, ".sum"},   32'(rsp_sum4),   32'(s));
    check({tag, ".cout"},  32'(rsp_cout4),  32'(c));
    check({tag, ".id"},    32'(rsp_id4),    32'(id));
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    req_valid4 = '0;
    a4         = '0;
    b4         = '0;
    rsp_ready4 = 1'b1;
    req_valid3 = '0;
    a3         = '0;
    b3         = '0;
    rsp_ready3 = 1'b1;
`ifdef DL_ADDER_ARB_OVF_STICKY_EN
    ovf_clr    = 1'b0;
`endif

    // Reset state, and req_ready must stay low in reset even when a request is valid.
    #2;
    check_rsp4("reset", 1'b0, 8'h00, 1'b0, 2'd0);
    req_valid4 = 4'b0001;
    #1;
    check("reset.ready", 32'(req_ready4), 32'h0);
    req_valid4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle.valid", 32'(rsp_valid4), 32'h0);
    check("idle.ready", 32'(req_ready4), 32'h0);

    // Single add with carry (F0+20), then without carry (01+02).
    req_valid4  = 4'b0001;
    a4[7:0]     = 8'hF0;
    b4[7:0]     = 8'h20;
    #1;
    check("add1.ready", 32'(req_ready4), 32'h1);
    tick();
    check_rsp4("add1", 1'b1, 8'h10, 1'b1, 2'd0);
    a4[7:0]     = 8'h01;
    b4[7:0]     = 8'h02;
    #1;
    check("add2.ready", 32'(req_ready4), 32'h1);
    tick();
    check_rsp4("add2", 1'b1, 8'h03, 1'b0, 2'd0);
    req_valid4 = '0;
    tick();
    // Pop with no new accept: valid drops and the payload holds.
    check_rsp4("pop", 1'b0, 8'h03, 1'b0, 2'd0);

    // Round robin from pointer 0 with all four requesters valid.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a4[i*8 +: 8] = 8'(i + 1);
      b4[i*8 +: 8] = 8'h10;
    end
    req_valid4 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr%0d.ready", k), 32'(req_ready4), 32'(4'b0001 << (k % 4)));
      tick();
      check_rsp4($sformatf("rr%0d", k), 1'b1, 8'(8'h11 + (k % 4)), 1'b0, 2'(k % 4));
    end
    req_valid4 = '0;
    tick();
    check("rr.drain", 32'(rsp_valid4), 32'h0);

    // Backpressure. The pointer is now 2, so requester 0 is granted alone first.
    a4[7:0]    = 8'h05;
    b4[7:0]    = 8'h07;
    req_valid4 = 4'b0001;
    rsp_ready4 = 1'b0;
    tick();
    check_rsp4("bp.load", 1'b1, 8'h0C, 1'b0, 2'd0);
    a4[15:8]   = 8'h80;
    b4[15:8]   = 8'h80;
    a4[23:16]  = 8'h33;
    b4[23:16]  = 8'h44;
    req_valid4 = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.ready", k), 32'(req_ready4), 32'h0);
      tick();
      check_rsp4($sformatf("bp%0d", k), 1'b1, 8'h0C, 1'b0, 2'd0);
    end
    rsp_ready4 = 1'b1;
    #1;
    check("bp.rel.ready", 32'(req_ready4), 32'h2);
    tick();
    check_rsp4("bp.rel", 1'b1, 8'h00, 1'b1, 2'd1);
    req_valid4 = 4'b0100;
    #1;
    check("bp.r2.ready", 32'(req_ready4), 32'h4);
    tick();
    check_rsp4("bp.r2", 1'b1, 8'h77, 1'b0, 2'd2);
    req_valid4 = '0;
    tick();

    // Reset mid-operation. Granting req0 first moves the pointer to 1.
    a4[7:0]    = 8'h09;
    b4[7:0]    = 8'h01;
    req_valid4 = 4'b0001;
    rsp_ready4 = 1'b0;
    tick();
    check("mid.pre.valid", 32'(rsp_valid4), 32'h1);
    req_valid4 = '0;
    rst_n = 1'b0;
    #1;
    check("mid.async.valid", 32'(rsp_valid4), 32'h0);
    rst_n      = 1'b1;
    rsp_ready4 = 1'b1;
    req_valid4 = 4'b0011;
    #1;
    check("mid.ptr0.ready", 32'(req_ready4), 32'h1);
    tick();
    check_rsp4("mid.after", 1'b1, 8'h0A, 1'b0, 2'd0);
    req_valid4 = '0;
    tick();

    // Pointer wrap with NUM_REQ=3 (this instance's pointer is 0 after the last reset).
    a3         = {8'h30, 8'h10, 8'h01};
    b3         = {8'hD0, 8'h20, 8'h02};
    req_valid3 = 3'b100;
    #1;
    check("w3.r2.ready", 32'(req_ready3), 32'h4);
    tick();
    check("w3.r2.id",   32'(rsp_id3),   32'h2);
    check("w3.r2.sum",  32'(rsp_sum3),  32'h00);
    check("w3.r2.cout", 32'(rsp_cout3), 32'h1);
    req_valid3 = 3'b101;
    #1;
    check("w3.wrap.ready", 32'(req_ready3), 32'h1);
    tick();
    check("w3.wrap.id",  32'(rsp_id3),  32'h0);
    check("w3.wrap.sum", 32'(rsp_sum3), 32'h03);
    #1;
    check("w3.next.ready", 32'(req_ready3), 32'h4);
    tick();
    check("w3.next.id", 32'(rsp_id3), 32'h2);
    req_valid3 = '0;
    tick();
    check("w3.drain", 32'(rsp_valid3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
